bus_invert_decoder: RTL
=======================

# bus_invert_decoder

Receive-side stage of the bus-invert link: accepts the encoded word plus invert line produced by the bus-invert encoder, restores the original data, and hands it to the consumer through a valid/ready interface. A 2-entry buffer absorbs consumer backpressure. Optional counters measure the link's switching activity, encoded versus decoded, so the capacitance saving can be read out in silicon or simulation.

## Interface
Parameters:
- WIDTH, 8, data bus width in bits (encoded and decoded)
- CNT_W, 16, width of each activity counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enc_data  in  WIDTH  encoded bus word from the encoder
- enc_inv  in  1  invert line accompanying enc_data
- enc_valid  in  1  enc_data/enc_inv hold a beat
- enc_ready  out  1  block can accept a beat this cycle
- dec_data  out  WIDTH  restored data word
- dec_valid  out  1  dec_data holds a beat
- dec_ready  in  1  consumer accepts dec_data this cycle
- stats_clr  in  1  synchronous clear of both activity counters
- tog_enc  out  CNT_W  accumulated toggles on encoded bus plus invert line
- tog_raw  out  CNT_W  accumulated toggles the uninverted data would have caused

## Operation
- Accept: enc_valid && enc_ready at a rising edge. Drive: dec_valid && dec_ready.
- Decode: stored word = enc_data XOR {WIDTH{enc_inv}}; stored already decoded, so no decode logic sits on dec_data.
- Buffer: 2-entry FIFO, occupancy count 0..2. enc_ready = (count != 2), from registered count only (no combinational path from dec_ready). dec_valid = (count != 0); dec_data = head entry.
- Push only: count+1. Pop only: count-1, second entry becomes head. Push+pop with count 1: count stays 1, new word becomes head. Push+pop with count 0 is impossible (dec_valid low). count 2 never pushes.
- Order strictly preserved; no beat dropped or duplicated.
- Activity: previous accepted encoded word prev_enc (WIDTH+1 bits incl. inv) and previous decoded word prev_raw are kept. Per accepted beat: tog_enc += popcount({enc_inv,enc_data} XOR prev_enc); tog_raw += popcount(decoded XOR prev_raw); both prev registers then update. History updates only on accepted beats.
- Counters saturate at 2^CNT_W-1; no wrap.
- stats_clr high: both counters become 0 at that edge; a beat accepted in the same cycle updates history but contributes nothing (clear wins).

## Timing
- Reset values (asynchronous, while rst_n low): count 0, enc_ready 1, dec_valid 0, dec_data 0, FIFO entries 0, prev_enc 0, prev_raw 0, tog_enc 0, tog_raw 0. prev values 0 match encoder reset state.
- Reset mid-operation: all buffered beats discarded; no partial output after release.
- Latency: beat accepted at edge N appears on dec_data with dec_valid high immediately after edge N (one cycle).
- Throughput: one beat per cycle sustained while dec_ready held high.
- Counter update visible one cycle after accepting edge.
- Backpressure: after dec_ready drops, at most 2 beats accepted before enc_ready falls; enc_ready rises the cycle after the pop that frees a slot.

## Configuration
- BI_DECODER_STATS_EN defined: activity history, counters and stats_clr logic present as above.
- Not defined: history and counter registers removed; tog_enc and tog_raw tied to 0; stats_clr ignored. Data path and handshake identical.

## Test plan
- Reset: assert rst_n low mid-stream with 2 beats buffered -> dec_valid 0, enc_ready 1, dec_data 0x00, counters 0 asynchronously; no stale beat after release.
- Decode: dec_ready 1, send (0x5A,inv 0) then (0x5A,inv 1) -> dec_data 0x5A then 0xA5, each one cycle after acceptance.
- Backpressure: dec_ready 0, offer 0x11,0x22,0x33 continuously -> only 0x11,0x22 accepted, enc_ready 0; raise dec_ready -> output 0x11,0x22,0x33 in order, no loss.
- Push+pop at count 1: stream 16 beats with dec_ready 1 -> enc_ready never drops, outputs match input order.
- Activity (STATS_EN): from reset send raw 0xFF as (0x00,inv 1), then raw 0x00 as (0x00,inv 0) -> tog_enc 2, tog_raw 16; stats_clr with a third beat -> both 0.
- Saturation (CNT_W=4): repeat the alternating pair 3 times -> tog_raw holds 15, tog_enc 6; macro undefined -> both stay 0.

Source files
------------

// File: rtl/bus_invert_decoder.sv
// Bus-invert link receiver: restores data from (enc_data, enc_inv) into a 2-entry output FIFO.
// Define BI_DECODER_STATS_EN to build the encoded/decoded switching-activity counters.
module bus_invert_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] enc_data,
  input  logic             enc_inv,
  input  logic             enc_valid,
  output logic             enc_ready,
  output logic [WIDTH-1:0] dec_data,
  output logic             dec_valid,
  input  logic             dec_ready,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] tog_enc,
  output logic [CNT_W-1:0] tog_raw
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push_s, pop_s;
  logic [WIDTH-1:0] decoded_s;

  // Handshakes come from the registered count only, so dec_ready never reaches enc_ready.
  assign enc_ready = (count_q != 2'd2);
  assign dec_valid = (count_q != 2'd0);
  assign dec_data  = head_q;
  assign push_s    = enc_valid && enc_ready;
  assign pop_s     = dec_valid && dec_ready;
  assign decoded_s = enc_data ^ {WIDTH{enc_inv}};

  // FIFO next state; push+pop only occurs at count 1, where the new word replaces the head.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push_s, pop_s})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_d = decoded_s;
        end else begin
          tail_d = decoded_s;
        end
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        head_d  = tail_q;
      end
      2'b11: begin
        head_d = decoded_s;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef BI_DECODER_STATS_EN
  localparam int PC_W  = $clog2(WIDTH + 2);
  localparam int SUM_W = CNT_W + PC_W + 1;

  logic [WIDTH:0]   prev_enc_q, prev_enc_d;
  logic [WIDTH-1:0] prev_raw_q, prev_raw_d;
  logic [CNT_W-1:0] tog_enc_q, tog_enc_d;
  logic [CNT_W-1:0] tog_raw_q, tog_raw_d;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      n = n + {{(PC_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [PC_W-1:0]  inc);
    logic [SUM_W-1:0] s;
    s = {{(SUM_W-CNT_W){1'b0}}, acc} + {{(SUM_W-PC_W){1'b0}}, inc};
    if (s > {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}}) begin
      return {CNT_W{1'b1}};
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  // History follows every accepted beat; a clear in the same cycle discards its contribution.
  always_comb begin
    prev_enc_d = prev_enc_q;
    prev_raw_d = prev_raw_q;
    tog_enc_d  = tog_enc_q;
    tog_raw_d  = tog_raw_q;
    if (push_s) begin
      prev_enc_d = {enc_inv, enc_data};
      prev_raw_d = decoded_s;
    end else begin
      prev_enc_d = prev_enc_q;
    end
    if (stats_clr) begin
      tog_enc_d = '0;
      tog_raw_d = '0;
    end else if (push_s) begin
      tog_enc_d = sat_add(tog_enc_q, popcount({enc_inv, enc_data} ^ prev_enc_q));
      tog_raw_d = sat_add(tog_raw_q, popcount({1'b0, decoded_s ^ prev_raw_q}));
    end else begin
      tog_enc_d = tog_enc_q;
    end
  end

  // Activity history and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_enc_q <= '0;
      prev_raw_q <= '0;
      tog_enc_q  <= '0;
      tog_raw_q  <= '0;
    end else begin
      prev_enc_q <= prev_enc_d;
      prev_raw_q <= prev_raw_d;
      tog_enc_q  <= tog_enc_d;
      tog_raw_q  <= tog_raw_d;
    end
  end

  assign tog_enc = tog_enc_q;
  assign tog_raw = tog_raw_q;
`else
  logic unused_stats_clr_s;

  assign unused_stats_clr_s = stats_clr;
  assign tog_enc = '0;
  assign tog_raw = '0;
`endif

endmodule
